// File: rtl/cc_host_pkg.sv
// Shared constants for the compute core host initiator:
// request opcodes, response status codes and FSM state encoding.
package cc_host_pkg;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_READ = 2'd1;
  localparam logic [1:0] OP_EXEC = 2'd2;
  localparam logic [1:0] OP_CMD1 = 2'd3;

  localparam logic [1:0] ST_READ_OK   = 2'd0;
  localparam logic [1:0] ST_EXEC_DONE = 2'd1;
  localparam logic [1:0] ST_EXEC_TMO  = 2'd2;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_LOAD      = 4'd1;
  localparam logic [3:0] S_RD_ADDR   = 4'd2;
  localparam logic [3:0] S_RD_WAIT   = 4'd3;
  localparam logic [3:0] S_EX_ISSUE  = 4'd4;
  localparam logic [3:0] S_EX_WAIT   = 4'd5;
  localparam logic [3:0] S_EX_CLEAR  = 4'd6;
  localparam logic [3:0] S_EX_SETTLE = 4'd7;
  localparam logic [3:0] S_RSP       = 4'd8;

  localparam logic [4:0] INS_IDLE = 5'd0;

endpackage

// File: rtl/compute_core_host.sv
// Host-side initiator for the compute core's external command/BRAM port.
// Sequences loads, reads and instruction execution; returns read data or status.
module compute_core_host
  import cc_host_pkg::*;
#(
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 1 << 20,
  parameter int CNT_W   = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [9:0]  req_addr,
  input  logic [63:0] req_data,
  input  logic [34:0] req_cmd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic [1:0]  rsp_status,
  output logic [9:0]  address_ext,
  output logic [63:0] dina_ext,
  output logic        wea_ext,
  output logic [34:0] command_in,
  output logic        command_we0,
  output logic        command_we1,
  input  logic [63:0] doutb_ext,
  input  logic        done_ins_computation
);

  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);

  logic [3:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             ex_done;
  logic             ex_tmo;

  assign req_ready = (state == S_IDLE) && !rst;
  assign rsp_valid = (state == S_RSP);

  // first EX_WAIT cycle (cnt==0) still sees the core's old command
  assign ex_done = done_ins_computation && (cnt != '0);
  assign ex_tmo  = (cnt == TMO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rsp_data    <= '0;
      rsp_status  <= '0;
      address_ext <= '0;
      dina_ext    <= '0;
      wea_ext     <= 1'b0;
      command_in  <= '0;
      command_we0 <= 1'b0;
      command_we1 <= 1'b0;
    end else begin
      wea_ext     <= 1'b0;
      command_we0 <= 1'b0;
      command_we1 <= 1'b0;
      command_in  <= '0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            unique case (1'b1)
              req_op == OP_LOAD: begin
                address_ext <= req_addr;
                dina_ext    <= req_data;
                wea_ext     <= 1'b1;
                state       <= S_LOAD;
              end
              req_op == OP_CMD1: begin
                command_in  <= req_cmd;
                command_we1 <= 1'b1;
                state       <= S_LOAD;
              end
              req_op == OP_READ: begin
                address_ext <= req_addr;
                state       <= S_RD_ADDR;
              end
              default: begin
                command_in  <= req_cmd;
                command_we0 <= 1'b1;
                state       <= S_EX_ISSUE;
              end
            endcase
          end
        end
        S_LOAD: state <= S_IDLE;
        S_RD_ADDR: begin
          cnt   <= '0;
          state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (cnt == RD_LAST) begin
            rsp_data   <= doutb_ext;
            rsp_status <= ST_READ_OK;
            state      <= S_RSP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_EX_ISSUE: begin
          cnt   <= '0;
          state <= S_EX_WAIT;
        end
        S_EX_WAIT: begin
          if (ex_done || ex_tmo) begin
            rsp_data    <= 64'(cnt);
            rsp_status  <= ex_done ? ST_EXEC_DONE : ST_EXEC_TMO;
            command_in  <= {30'd0, INS_IDLE};
            command_we0 <= 1'b1;
            state       <= S_EX_CLEAR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_EX_CLEAR:  state <= S_EX_SETTLE;
        S_EX_SETTLE: state <= S_RSP;
        S_RSP: if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_compute_core_host.sv
// Randomized bench for compute_core_host with a stub core (BRAM + exec)
// and a memory/timing reference model.
module tb_compute_core_host;
  import cc_host_pkg::*;

  localparam int RD_LAT  = 2;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [9:0]  req_addr = '0;
  logic [63:0] req_data = '0;
  logic [34:0] req_cmd = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_status;
  logic [9:0]  address_ext;
  logic [63:0] dina_ext;
  logic        wea_ext;
  logic [34:0] command_in;
  logic        command_we0;
  logic        command_we1;
  logic [63:0] doutb_ext;
  logic        done_ins_computation;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  compute_core_host #(
    .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr),
    .req_data(req_data), .req_cmd(req_cmd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_status(rsp_status),
    .address_ext(address_ext), .dina_ext(dina_ext),
    .wea_ext(wea_ext), .command_in(command_in),
    .command_we0(command_we0), .command_we1(command_we1),
    .doutb_ext(doutb_ext),
    .done_ins_computation(done_ins_computation)
  );

  function automatic bit ins_ok(input logic [4:0] ins);
    return ins inside {5'd18, 5'd19, 5'd20, 5'd22, 5'd23, 5'd24};
  endfunction

  // stub core: registered BRAM read pipeline and an exec engine
  logic [63:0] mem [1024] = '{default: '0};
  logic [63:0] pipe [RD_LAT] = '{default: '0};
  logic        running = 1'b0;
  int          ex_cnt = 0;
  int          stub_delay = 1;

  always @(posedge clk) begin
    if (wea_ext) mem[address_ext] <= dina_ext;
    pipe[0] <= mem[address_ext];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    if (rst) begin
      running <= 1'b0;
    end else if (command_we0) begin
      running <= ins_ok(command_in[4:0]);
      ex_cnt  <= 0;
    end else if (running) begin
      ex_cnt <= ex_cnt + 1;
    end
  end

  assign doutb_ext = pipe[RD_LAT-1];
  assign done_ins_computation = running && (ex_cnt >= stub_delay);

  int          we0_n = 0;
  int          we1_n = 0;
  int          clr_cyc = -1;
  logic [34:0] we1_val = '0;

  always @(negedge clk) begin
    if (command_we0) begin
      we0_n <= we0_n + 1;
      if (command_in == '0) clr_cyc <= cyc;
    end
    if (command_we1) begin
      we1_n   <= we1_n + 1;
      we1_val <= command_in;
    end
  end

  logic [63:0] ref_mem [1024] = '{default: '0};

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [9:0] a,
                      input logic [63:0] d, input logic [34:0] c,
                      output int t);
    int n = 0;
    req_valid = 1'b1;
    req_op = op;
    req_addr = a;
    req_data = d;
    req_cmd = c;
    while (!req_ready && n < 300) begin
      tick();
      n++;
    end
    if (!req_ready) chk("req_ready_wait", 64'(req_ready), 64'd1);
    t = cyc;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag, input int t_exp,
                         input logic [1:0] st, input logic [63:0] d);
    int n = 0;
    while (!rsp_valid && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_cycle"}, 64'(cyc), 64'(t_exp));
    chk({tag, "_status"}, 64'(rsp_status), 64'(st));
    chk({tag, "_data"}, rsp_data, d);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic do_load(input logic [9:0] a, input logic [63:0] d);
    int t;
    send(OP_LOAD, a, d, '0, t);
    chk("load_wea", 64'(wea_ext), 64'd1);
    chk("load_addr", 64'(address_ext), 64'(a));
    chk("load_din", dina_ext, d);
    chk("load_busy", 64'(req_ready), 64'd0);
    tick();
    chk("load_ready", 64'(req_ready), 64'd1);
    chk("load_wea_off", 64'(wea_ext), 64'd0);
    ref_mem[a] = d;
  endtask

  task automatic do_read(input logic [9:0] a);
    int t;
    send(OP_READ, a, '0, '0, t);
    chk("read_addr", 64'(address_ext), 64'(a));
    get_rsp("read", t + 2 + RD_LAT, ST_READ_OK, ref_mem[a]);
  endtask

  task automatic do_exec(input logic [34:0] c, input int dly);
    int t;
    int cnt;
    logic [1:0] st;
    stub_delay = dly;
    if (ins_ok(c[4:0]) && dly <= TIMEOUT) begin
      st = ST_EXEC_DONE;
      cnt = (dly < 1) ? 1 : dly;
    end else begin
      st = ST_EXEC_TMO;
      cnt = TIMEOUT;
    end
    send(OP_EXEC, '0, '0, c, t);
    chk("exec_we0", 64'(command_we0), 64'd1);
    chk("exec_cmd", 64'(command_in), 64'(c));
    get_rsp("exec", t + 5 + cnt, st, 64'(cnt));
    chk("exec_clear", 64'(clr_cyc), 64'(t + 3 + cnt));
  endtask

  task automatic do_cmd1(input logic [34:0] c);
    int t;
    int w1;
    int w0;
    w1 = we1_n;
    w0 = we0_n;
    send(OP_CMD1, '0, '0, c, t);
    chk("cmd1_we1", 64'(command_we1), 64'd1);
    chk("cmd1_val", 64'(command_in), 64'(c));
    tick();
    tick();
    chk("cmd1_pulses", 64'(we1_n), 64'(w1 + 1));
    chk("cmd1_pval", 64'(we1_val), 64'(c));
    chk("cmd1_no_we0", 64'(we0_n), 64'(w0));
    chk("cmd1_no_rsp", 64'(rsp_valid), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 64'({req_ready, rsp_valid, rsp_status,
        wea_ext, command_we0, command_we1}), 64'd0);
    chk({tag, "_rdata"}, rsp_data, 64'd0);
    chk({tag, "_addr"}, 64'(address_ext), 64'd0);
    chk({tag, "_din"}, dina_ext, 64'd0);
    chk({tag, "_cmd"}, 64'(command_in), 64'd0);
  endtask

  logic [4:0] ins_tab [8] = '{5'd18, 5'd19, 5'd20, 5'd22,
                              5'd23, 5'd24, 5'd5, 5'd31};

  initial begin
    int t;
    logic [9:0] a;
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(req_ready), 64'd1);
    tick();

    do_load(10'd5, 64'hDEAD_BEEF_0123_4567);
    do_read(10'd5);
    do_exec({30'd0, 5'd22}, 10);
    do_exec({30'h2A5, 5'd5}, 10);
    do_exec({30'd7, 5'd22}, TIMEOUT);
    do_exec({30'd9, 5'd24}, TIMEOUT + 1);
    do_exec({30'd0, 5'd18}, 1);
    do_load(10'd1023, 64'hFFFF_0000_FFFF_0001);
    do_read(10'd1023);

    // response back-pressure
    send(OP_READ, 10'd5, '0, '0, t);
    repeat (RD_LAT + 1) tick();
    for (int i = 0; i < 20; i++) begin
      chk("stall_valid", 64'(rsp_valid), 64'd1);
      chk("stall_data", rsp_data, 64'hDEAD_BEEF_0123_4567);
      chk("stall_status", 64'(rsp_status), 64'(ST_READ_OK));
      chk("stall_ready", 64'(req_ready), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("stall_release", 64'(rsp_valid), 64'd0);

    // reset in the middle of an execution
    stub_delay = 200;
    send(OP_EXEC, '0, '0, {30'd0, 5'd22}, t);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk_zero("midrst");
    rst = 1'b0;
    #1;
    chk("midrst_ready", 64'(req_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
      tick();
    end
    do_read(10'd5);

    do_cmd1(35'h1_2345_6789);

    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 9) == 0) ? 10'd1023
          : 10'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: do_load(a, {$urandom, $urandom});
        1: do_read(a);
        2: do_exec({30'($urandom), ins_tab[$urandom_range(0, 7)]},
                   $urandom_range(1, 70));
        default: do_cmd1(35'({$urandom, $urandom}) | 35'd1);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/compute_core_host.md
# compute_core_host

Host-side initiator for the compute core's external command/BRAM port. Accepts a request stream (load word, read word, execute instruction, write command register 1), sequences the core's `command_in`/`command_we0`/`command_we1`, `address_ext`/`dina_ext`/`wea_ext` pins, waits for `done_ins_computation` with a timeout, and returns read data or execution status on a response stream. It sits between the system controller (or a test sequencer) and the compute core. It is the only master of the core's external pins.

## Interface
- `RD_LAT`, default 1: core BRAM read latency in cycles, from `address_ext` to `doutb_ext`. Legal values are 1 and 2.
- `TIMEOUT`, default 2^20: maximum number of EX_WAIT cycles before an execution is abandoned.
- `CNT_W`, default 24: width of the cycle counter. Must satisfy 2^CNT_W > TIMEOUT.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_op  in  2  request type: 0=LOAD, 1=READ, 2=EXEC, 3=CMD1
- req_addr  in  10  BRAM word address (LOAD, READ)
- req_data  in  64  write data (LOAD)
- req_cmd  in  35  instruction word `{OP3,OP2,OP1,INS}` (EXEC, CMD1)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_data  out  64  READ: BRAM word; EXEC: zero-extended cycle count
- rsp_status  out  2  0=READ ok, 1=EXEC done, 2=EXEC timeout
- address_ext  out  10  to core
- dina_ext  out  64  to core
- wea_ext  out  1  to core
- command_in  out  35  to core
- command_we0  out  1  to core
- command_we1  out  1  to core
- doutb_ext  in  64  from core
- done_ins_computation  in  1  from core

## Operation
- States: IDLE, LOAD, RD_ADDR, RD_WAIT, EX_ISSUE, EX_WAIT, EX_CLEAR, EX_SETTLE, RSP.
- req_ready is 1 only in IDLE. All core-side outputs are registered.
- The core is idle only while command register 0 holds INS=0. In that state OP1=OP3=0, so `address_ext` is an absolute BRAM address.
- **LOAD:** IDLE→LOAD. For one cycle drive address_ext=req_addr, dina_ext=req_data, wea_ext=1, then return to IDLE. No response is produced.
- **CMD1:** IDLE→LOAD. For one cycle drive command_in=req_cmd, command_we1=1, then return to IDLE. No response is produced.
- **READ:** IDLE→RD_ADDR. address_ext=req_addr and is held until IDLE. The state then advances through RD_WAIT. doutb_ext is captured RD_LAT cycles after address_ext is first driven. Then enter RSP with status 0.
- **EXEC:**
  - IDLE→EX_ISSUE: command_in=req_cmd, command_we0=1 for one cycle.
  - EX_WAIT: the counter starts at 0 and increments each cycle. done is ignored in the first EX_WAIT cycle, because the core's register is still updating.
  - Exit EX_WAIT on done=1 (status 1) or when counter==TIMEOUT (status 2). Done takes priority if both occur in the same cycle.
  - EX_CLEAR: command_in=0, command_we0=1 for one cycle. This returns the core to idle.
  - EX_SETTLE: one cycle, then RSP. rsp_data holds the counter value at exit.
- **RSP:** rsp_valid=1 and rsp_data/rsp_status stay stable until rsp_ready. Then go to IDLE. rsp_ready sampled while not in RSP is ignored.
- Outside their active state, wea_ext, command_we0 and command_we1 are 0. command_in returns to 0.
- An EXEC with an INS that is not 18/19/20/22/23/24 times out with status 2.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_status=0, all core-side outputs 0. The state is IDLE, and req_ready=1 from the first cycle after rst is deasserted.
- Reset mid-operation abandons the transaction immediately. No response is issued, and outputs return to their reset values.
- LOAD accepted at cycle t: wea_ext=1 at t+1, req_ready=1 at t+2. Throughput is one LOAD per 2 cycles.
- READ accepted at t: address_ext valid from t+1, rsp_valid at t+2+RD_LAT.
- EXEC accepted at t: command_we0 pulse at t+1. done is sampled from t+3. If done is seen at cycle d: clear pulse at d+1, rsp_valid at d+3, count = d−(t+2).
- Timeout: done never seen, rsp_valid at t+2+TIMEOUT+3, status 2, count=TIMEOUT.

## Structure
- Shared package `cc_host_pkg`: opcode constants (LOAD/READ/EXEC/CMD1), status constants, state encoding, INS_IDLE=5'd0.
- The block is a single module; no sub-module is needed. The timeout counter is inline.

## Test plan
- LOAD addr 5, data 64'hDEAD_BEEF_0123_4567, then READ addr 5 → rsp_status 0, rsp_data 64'hDEAD_BEEF_0123_4567 at t+2+RD_LAT.
- EXEC INS=22, with a stub core asserting done 10 cycles after the command → status 1, count 10. A command_we0 pulse with command_in=0 follows done by exactly 1 cycle.
- EXEC INS=5 (no done) with TIMEOUT=64 → status 2, count 64, clear pulse issued.
- Hold rsp_ready=0 for 20 cycles after a READ → rsp_valid, rsp_data and rsp_status stable, req_ready=0 throughout.
- Assert rst during EX_WAIT → next cycle all outputs 0, no rsp_valid; the following READ completes normally.
- CMD1 req_cmd=35'h1_2345_6789 → single command_we1 pulse carrying that value, command_we0 stays 0, no response.
